ecc_op_sequencer: RTL and testbench
===================================

Name: ecc_op_sequencer

Overview:
- Sequences one ECC operation through the datapath stages (encoder, noise adder, decoder) after the APB register file raises start.
- Latches the operating mode from CTRL and the codeword width from CODEWORD_WIDTH, then issues per-stage enable pulses and waits for each stage's done.
- Reports completion and status back to the register file.
- Sits between the APB register block and the ECC datapath.

Parameters:
- AMBA_WORD, 32, width of the CTRL and CODEWORD_WIDTH register inputs.
- TIMEOUT_CYCLES, 16, maximum cycles a stage may take to return done (legal range 2..255).
- CNT_WIDTH, 8, width of the stage timeout counter (must hold TIMEOUT_CYCLES-1).

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- start, input, 1: operation request from the register file.
- CTRL, input, AMBA_WORD: mode in bits [1:0]: 0 = encode, 1 = decode, 2 = full channel (encode, noise, decode), 3 = illegal.
- CODEWORD_WIDTH, input, AMBA_WORD: width code in bits [1:0]: 0 = 8, 1 = 16, 2 = 32, 3 = illegal.
- enc_done, input, 1: encoder result valid.
- dec_done, input, 1: decoder result valid.
- enc_en, output, 1: one-cycle encoder launch pulse.
- noise_en, output, 1: one-cycle noise-adder launch pulse.
- dec_en, output, 1: one-cycle decoder launch pulse.
- width_sel, output, 2: latched width code, driven to every stage.
- busy, output, 1: high whenever the state is not IDLE.
- operation_done, output, 1: one-cycle completion pulse.
- op_status, output, 2: 00 = ok, 01 = illegal config, 10 = timeout; valid from the operation_done cycle.
- start_dropped, output, 1: one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state goes to IDLE and the timeout counter clears.
  - enc_en, noise_en, dec_en, busy, operation_done, start_dropped, width_sel and op_status all go to 0.
  - Reset mid-operation aborts immediately: no operation_done is issued and a late done input is ignored.
- States:
  - IDLE: start = 1 moves to LATCH. CTRL and CODEWORD_WIDTH are not sampled here.
  - LATCH: captures mode = CTRL[1:0] and width_sel = CODEWORD_WIDTH[1:0]. If mode = 3 or width = 3, go to ERR with status 01. Mode 0 or 2 goes to ENC; mode 1 goes to DEC.
  - ENC: enc_en = 1 only in the first cycle. Counter clears on entry and increments each cycle with no done. enc_done = 1, sampled in every ENC cycle including the first, moves to NOISE if mode = 2, else to DONE.
  - NOISE: exactly one cycle with noise_en = 1 (the noise adder has fixed 1-cycle latency), then DEC.
  - DEC: dec_en = 1 only in the first cycle. Counter behaves as in ENC. dec_done = 1 moves to DONE.
  - DONE: operation_done = 1, op_status = 00, then IDLE.
  - ERR: operation_done = 1 with status 01 or 10, then IDLE.
- Timeout:
  - In ENC or DEC, if counter = TIMEOUT_CYCLES-1 and done = 0, go to ERR with status 10.
  - A stage therefore gets exactly TIMEOUT_CYCLES cycles.
  - If done and the timeout condition occur in the same cycle, done wins.
- Done inputs:
  - enc_done is ignored outside ENC; dec_done is ignored outside DEC.
  - A done that stays high across stages does not skip the next stage: it is only sampled in the state for its own stage.
- start while not IDLE (including DONE and ERR): the request is ignored and start_dropped pulses in that same cycle.
- width_sel and op_status hold their values until the next LATCH, which clears op_status to 00.
- Latency: start sampled at edge T gives LATCH at T+1 and ENC at T+2. If the stage done returns in its first cycle:
  - encode-only: operation_done at T+3.
  - full channel: operation_done at T+5.
- busy falls in the cycle after operation_done.

Test Plan:
- Reset then idle: rst = 0 for 2 cycles, rst = 1 -> all outputs 0, busy = 0.
- Encode, 16-bit: CTRL = 0, CODEWORD_WIDTH = 1, start at T, enc_done at T+4 -> enc_en only at T+2, width_sel = 1 from T+2, operation_done at T+5, op_status = 00, noise_en and dec_en never asserted.
- Full channel: CTRL = 2, CODEWORD_WIDTH = 2, enc_done and dec_done each in their stage's first cycle -> enc_en at T+2, noise_en at T+3, dec_en at T+4, operation_done at T+5, status 00.
- Illegal config: CTRL = 3, start at T -> no enables asserted, operation_done at T+2, op_status = 01. Repeat with CODEWORD_WIDTH = 3 -> same response.
- Timeout: decode mode, dec_done held 0 -> ERR after exactly 16 DEC cycles, operation_done with status 10. With dec_done arriving in the 16th DEC cycle -> status 00 (done wins).
- Overlap and abort:
  - start pulsed during ENC -> start_dropped pulses and the result is unchanged.
  - rst = 0 during DEC -> IDLE next cycle, no operation_done, a later dec_done is ignored.

Source files
------------

// File: rtl/ecc_op_sequencer.sv
// ECC operation sequencer: walks one encode / decode / full-channel
// operation through the datapath stages and reports completion status.
module ecc_op_sequencer #(
    parameter int AMBA_WORD      = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic                 enc_done,
    input  logic                 dec_done,
    output logic                 enc_en,
    output logic                 noise_en,
    output logic                 dec_en,
    output logic [1:0]           width_sel,
    output logic                 busy,
    output logic                 operation_done,
    output logic [1:0]           op_status,
    output logic                 start_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ENC,
        S_NOISE,
        S_DEC,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_CFG = 2'b01;
    localparam logic [1:0] ST_TO  = 2'b10;

    localparam logic [1:0] MODE_DEC  = 2'd1;
    localparam logic [1:0] MODE_FULL = 2'd2;
    localparam logic [1:0] MODE_BAD  = 2'd3;
    localparam logic [1:0] WIDTH_BAD = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           width_q, width_d;
    logic [1:0]           status_q, status_d;

    // Only the low two bits of each register word carry meaning.
    logic unused_upper;
    assign unused_upper = ^{CTRL[AMBA_WORD-1:2],
                            CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // State, stage counter and latched configuration registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            width_q  <= 2'b00;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            width_q  <= width_d;
            status_q <= status_d;
        end
    end

    // Next-state logic and per-state launch / completion pulses.
    // The counter is zero only in a stage's first cycle, which is
    // what qualifies the launch pulse.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        width_d        = width_q;
        status_d       = status_q;
        enc_en         = 1'b0;
        noise_en       = 1'b0;
        dec_en         = 1'b0;
        operation_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                mode_d   = CTRL[1:0];
                width_d  = CODEWORD_WIDTH[1:0];
                status_d = ST_OK;
                cnt_d    = '0;
                if (CTRL[1:0] == MODE_BAD ||
                    CODEWORD_WIDTH[1:0] == WIDTH_BAD) begin
                    state_d  = S_ERR;
                    status_d = ST_CFG;
                end else if (CTRL[1:0] == MODE_DEC) begin
                    state_d = S_DEC;
                end else begin
                    state_d = S_ENC;
                end
            end

            S_ENC: begin
                enc_en = (cnt_q == '0);
                if (enc_done) begin
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_FULL) ? S_NOISE : S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_ERR;
                    status_d = ST_TO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Noise adder has a fixed single-cycle latency.
            S_NOISE: begin
                noise_en = 1'b1;
                cnt_d    = '0;
                state_d  = S_DEC;
            end

            S_DEC: begin
                dec_en = (cnt_q == '0);
                if (dec_done) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_ERR;
                    status_d = ST_TO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                operation_done = 1'b1;
                status_d       = ST_OK;
                cnt_d          = '0;
                state_d        = S_IDLE;
            end

            S_ERR: begin
                operation_done = 1'b1;
                cnt_d          = '0;
                state_d        = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign start_dropped = start && busy;
    assign width_sel     = width_q;
    assign op_status     = status_q;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer: directed vector table,
// hand-written reset sequences and random operations vs. a model.
module tb_ecc_op_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] CTRL;
    logic [31:0] CODEWORD_WIDTH;
    logic        enc_done;
    logic        dec_done;
    logic        enc_en;
    logic        noise_en;
    logic        dec_en;
    logic [1:0]  width_sel;
    logic        busy;
    logic        operation_done;
    logic [1:0]  op_status;
    logic        start_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ecc_op_sequencer #(
        .AMBA_WORD(32),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .CTRL(CTRL),
        .CODEWORD_WIDTH(CODEWORD_WIDTH),
        .enc_done(enc_done),
        .dec_done(dec_done),
        .enc_en(enc_en),
        .noise_en(noise_en),
        .dec_en(dec_en),
        .width_sel(width_sel),
        .busy(busy),
        .operation_done(operation_done),
        .op_status(op_status),
        .start_dropped(start_dropped)
    );

    typedef struct {
        int enc_first;
        int enc_cnt;
        int noise_first;
        int noise_cnt;
        int dec_first;
        int dec_cnt;
        int done_first;
        int done_cnt;
        int status;
        int drop_cnt;
        int busy_after;
        int width;
    } obs_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] cw;
        int          enc_lat;
        int          dec_lat;
        int          drop_at;
        bit          hold;
        int          x_enc;
        int          x_noise;
        int          x_dec;
        int          x_done;
        int          x_status;
        int          x_drop;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Operation-level model: cycle offsets counted from the start cycle.
    function automatic obs_t model(input logic [31:0] ctrl,
                                   input logic [31:0] cw,
                                   input int enc_lat,
                                   input int dec_lat,
                                   input int drop_at);
        obs_t e;
        logic [1:0] mode;
        logic [1:0] w;
        int t;
        bit to;
        mode = ctrl[1:0];
        w    = cw[1:0];
        e = '{-1, 0, -1, 0, -1, 0, -1, 0, -1, 0, -1, 0};
        t  = 2;
        to = 1'b0;
        if (mode == 2'd3 || w == 2'd3) begin
            e.done_first = 2;
            e.status     = 1;
        end else begin
            if (mode != 2'd1) begin
                e.enc_first = t;
                e.enc_cnt   = 1;
                if (enc_lat < TO) t += enc_lat + 1;
                else begin t += TO; to = 1'b1; end
            end
            if (!to && mode == 2'd2) begin
                e.noise_first = t;
                e.noise_cnt   = 1;
                t += 1;
            end
            if (!to && mode != 2'd0) begin
                e.dec_first = t;
                e.dec_cnt   = 1;
                if (dec_lat < TO) t += dec_lat + 1;
                else begin t += TO; to = 1'b1; end
            end
            e.done_first = t;
            e.status     = to ? 2 : 0;
        end
        e.done_cnt   = 1;
        e.busy_after = 0;
        e.width      = int'(w);
        e.drop_cnt   = (drop_at >= 1 && drop_at <= e.done_first) ? 1 : 0;
        return e;
    endfunction

    // Drives one operation; stages answer enc_en/dec_en after a latency.
    task automatic run_op(input logic [31:0] ctrl,
                          input logic [31:0] cw,
                          input int enc_lat,
                          input int dec_lat,
                          input int drop_at,
                          input bit hold,
                          output obs_t o);
        int enc_at;
        int dec_at;
        bit fin;
        o = '{-1, 0, -1, 0, -1, 0, -1, 0, -1, 0, -1, -1};
        enc_at = -1;
        dec_at = -1;
        fin    = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (enc_en && enc_at < 0) enc_at = c;
            if (dec_en && dec_at < 0) dec_at = c;
            CTRL           = ctrl;
            CODEWORD_WIDTH = cw;
            start    = (c == 0) || (drop_at > 0 && c == drop_at);
            enc_done = (enc_at >= 0) &&
                       ((c - enc_at == enc_lat) ||
                        (hold && (c - enc_at > enc_lat)));
            dec_done = (dec_at >= 0) && (c - dec_at == dec_lat);
            #1;
            if (enc_en) begin
                o.enc_cnt++;
                if (o.enc_first < 0) o.enc_first = c;
            end
            if (noise_en) begin
                o.noise_cnt++;
                if (o.noise_first < 0) o.noise_first = c;
            end
            if (dec_en) begin
                o.dec_cnt++;
                if (o.dec_first < 0) o.dec_first = c;
            end
            if (start_dropped) o.drop_cnt++;
            if (o.done_first >= 0 && c == o.done_first + 1) begin
                o.busy_after = int'(busy);
                fin = 1'b1;
            end
            if (operation_done) begin
                o.done_cnt++;
                if (o.done_first < 0) begin
                    o.done_first = c;
                    o.status     = int'(op_status);
                    o.width      = int'(width_sel);
                end
            end
        end
        check("op_completed_in_budget", int'(fin), 1);
        start    = 1'b0;
        enc_done = 1'b0;
        dec_done = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".enc_first"},   o.enc_first,   e.enc_first);
        check({tag, ".enc_cnt"},     o.enc_cnt,     e.enc_cnt);
        check({tag, ".noise_first"}, o.noise_first, e.noise_first);
        check({tag, ".noise_cnt"},   o.noise_cnt,   e.noise_cnt);
        check({tag, ".dec_first"},   o.dec_first,   e.dec_first);
        check({tag, ".dec_cnt"},     o.dec_cnt,     e.dec_cnt);
        check({tag, ".done_first"},  o.done_first,  e.done_first);
        check({tag, ".done_cnt"},    o.done_cnt,    e.done_cnt);
        check({tag, ".status"},      o.status,      e.status);
        check({tag, ".dropped"},     o.drop_cnt,    e.drop_cnt);
        check({tag, ".busy_after"},  o.busy_after,  e.busy_after);
        check({tag, ".width_sel"},   o.width,       e.width);
    endtask

    vec_t vecs[13];

    initial begin
        obs_t o;
        obs_t e;
        int   seen_done;
        int   seen_busy;

        vecs[0]  = '{32'd0, 32'd1, 2, 0, 0, 1'b0, 2, -1, -1, 5, 0, 0};
        vecs[1]  = '{32'd2, 32'd2, 0, 0, 0, 1'b0, 2, 3, 4, 5, 0, 0};
        vecs[2]  = '{32'd3, 32'd0, 0, 0, 0, 1'b0, -1, -1, -1, 2, 1, 0};
        vecs[3]  = '{32'd0, 32'd3, 0, 0, 0, 1'b0, -1, -1, -1, 2, 1, 0};
        vecs[4]  = '{32'd1, 32'd0, 0, 99, 0, 1'b0, -1, -1, 2, 18, 2, 0};
        vecs[5]  = '{32'd1, 32'd0, 0, 15, 0, 1'b0, -1, -1, 2, 18, 0, 0};
        vecs[6]  = '{32'd0, 32'd2, 3, 0, 3, 1'b0, 2, -1, -1, 6, 0, 1};
        vecs[7]  = '{32'd2, 32'd1, 99, 0, 0, 1'b0, 2, -1, -1, 18, 2, 0};
        vecs[8]  = '{32'd1, 32'd2, 0, 0, 0, 1'b0, -1, -1, 2, 3, 0, 0};
        vecs[9]  = '{32'd0, 32'd0, 0, 0, 3, 1'b0, 2, -1, -1, 3, 0, 1};
        vecs[10] = '{32'd2, 32'd0, 0, 2, 0, 1'b1, 2, 3, 4, 7, 0, 0};
        vecs[11] = '{32'd3, 32'd1, 0, 0, 2, 1'b0, -1, -1, -1, 2, 1, 1};
        vecs[12] = '{32'hA5A5_A5A4, 32'h8000_0001, 1, 0, 0, 1'b0,
                     2, -1, -1, 4, 0, 0};

        rst            = 1'b0;
        start          = 1'b1;
        CTRL           = 32'd2;
        CODEWORD_WIDTH = 32'd2;
        enc_done       = 1'b1;
        dec_done       = 1'b1;

        // Reset held for two cycles with busy-looking inputs.
        repeat (2) @(negedge clk);
        #1;
        check("rst.busy",           int'(busy),           0);
        check("rst.enc_en",         int'(enc_en),         0);
        check("rst.noise_en",       int'(noise_en),       0);
        check("rst.dec_en",         int'(dec_en),         0);
        check("rst.operation_done", int'(operation_done), 0);
        check("rst.start_dropped",  int'(start_dropped),  0);
        check("rst.width_sel",      int'(width_sel),      0);
        check("rst.op_status",      int'(op_status),      0);
        rst      = 1'b1;
        start    = 1'b0;
        enc_done = 1'b0;
        dec_done = 1'b0;
        @(negedge clk);
        #1;
        check("idle.busy", int'(busy), 0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].ctrl, vecs[i].cw, vecs[i].enc_lat,
                   vecs[i].dec_lat, vecs[i].drop_at, vecs[i].hold, o);
            e = '{vecs[i].x_enc, (vecs[i].x_enc >= 0) ? 1 : 0,
                  vecs[i].x_noise, (vecs[i].x_noise >= 0) ? 1 : 0,
                  vecs[i].x_dec, (vecs[i].x_dec >= 0) ? 1 : 0,
                  vecs[i].x_done, 1, vecs[i].x_status, vecs[i].x_drop,
                  0, int'(vecs[i].cw[1:0])};
            compare($sformatf("vec%0d", i), o, e);
        end

        // Reset during DEC aborts; a late dec_done must be ignored.
        @(negedge clk);
        CTRL           = 32'd1;
        CODEWORD_WIDTH = 32'd0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("abort.dec_en", int'(dec_en), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort.busy",      int'(busy),           0);
        check("abort.done",      int'(operation_done), 0);
        check("abort.op_status", int'(op_status),      0);
        rst       = 1'b1;
        dec_done  = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (operation_done) seen_done++;
            if (busy) seen_busy++;
        end
        dec_done = 1'b0;
        check("abort.late_done_ignored", seen_done, 0);
        check("abort.stays_idle",        seen_busy, 0);

        // Random operations against the operation-level model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] rc;
            logic [31:0] rw;
            int el;
            int dl;
            int dr;
            bit hd;
            rc = $urandom();
            rw = $urandom();
            el = $urandom_range(0, 18);
            dl = $urandom_range(0, 18);
            hd = 1'($urandom_range(0, 1));
            e  = model(rc, rw, el, dl, 0);
            dr = ($urandom_range(0, 2) == 0) ?
                 $urandom_range(1, e.done_first) : 0;
            e  = model(rc, rw, el, dl, dr);
            run_op(rc, rw, el, dl, dr, hd, o);
            compare($sformatf("rand%0d", i), o, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
